// File: rtl/high_score_ram_ctrl.sv
// High-score RAM controller: shadows every user's record after reset, updates a user's record
// at game end when beaten, and clears the whole table on request.
module high_score_ram_ctrl #(
  parameter int unsigned NUM_USERS  = 6,
  parameter int unsigned SCORE_W    = 8,
  parameter int unsigned RAM_RD_LAT = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               access_granted,
  input  logic [2:0]         userID,
  input  logic               game_over,
  input  logic [SCORE_W-1:0] currentGameScore,
  input  logic               clear_req,
  input  logic [SCORE_W-1:0] ram_q,
  output logic [2:0]         ram_addr,
  output logic               ram_wren,
  output logic [SCORE_W-1:0] ram_data,
  output logic [SCORE_W-1:0] scoreUserAddr0,
  output logic [SCORE_W-1:0] scoreUserAddr1,
  output logic [SCORE_W-1:0] scoreUserAddr2,
  output logic [SCORE_W-1:0] scoreUserAddr3,
  output logic [SCORE_W-1:0] scoreUserAddr4,
  output logic [SCORE_W-1:0] scoreUserAddr5,
  output logic               busy,
  output logic               new_high_score
);

  localparam logic [2:0] ST_INIT  = 3'd0;
  localparam logic [2:0] ST_IDLE  = 3'd1;
  localparam logic [2:0] ST_CMP   = 3'd2;
  localparam logic [2:0] ST_WRITE = 3'd3;
  localparam logic [2:0] ST_CLEAR = 3'd4;

  localparam int unsigned CNT_W = (RAM_RD_LAT > 0) ? $clog2(RAM_RD_LAT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAM_RD_LAT);
  localparam logic [2:0] LAST = 3'(NUM_USERS - 1);

  logic [2:0]         r_state;
  logic [2:0]         r_addr;
  logic [CNT_W-1:0]   r_cnt;
  logic [SCORE_W-1:0] r_shadow [NUM_USERS];
  logic [2:0]         r_user;
  logic [SCORE_W-1:0] r_score;
  logic               r_pend;
  logic [2:0]         r_pend_user;
  logic [SCORE_W-1:0] r_pend_score;

  logic               w_go_req;
  logic               w_last;
  logic [SCORE_W-1:0] w_cur;
  logic               w_hit;
  logic               w_done;

  assign w_go_req = game_over & access_granted;
  assign w_last   = (r_addr == LAST);

  always_comb begin
    w_cur = '0;
    for (int unsigned i = 0; i < NUM_USERS; i++) begin
      if (r_user == 3'(i)) w_cur = r_shadow[i];
    end
  end

  // Out-of-range users never match and so never write.
  assign w_hit = (r_user <= LAST) && (r_score > w_cur);

  // Set on the last cycle of any busy operation that would otherwise return to IDLE.
  always_comb begin
    w_done = 1'b0;
    case (r_state)
      ST_INIT:  w_done = (r_cnt == CNT_MAX) && w_last;
      ST_CMP:   w_done = !w_hit;
      ST_WRITE: w_done = 1'b1;
      ST_CLEAR: w_done = w_last;
      default:  w_done = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_INIT;
      r_addr       <= '0;
      r_cnt        <= '0;
      r_user       <= '0;
      r_score      <= '0;
      r_pend       <= 1'b0;
      r_pend_user  <= '0;
      r_pend_score <= '0;
      for (int unsigned i = 0; i < NUM_USERS; i++) r_shadow[i] <= '0;
    end else begin
      if ((r_state != ST_IDLE) && w_go_req) begin
        r_pend       <= 1'b1;
        r_pend_user  <= userID;
        r_pend_score <= currentGameScore;
      end
      case (r_state)
        ST_INIT: begin
          if (r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + 1'b1;
          end else begin
            r_cnt <= '0;
            for (int unsigned i = 0; i < NUM_USERS; i++) begin
              if (r_addr == 3'(i)) r_shadow[i] <= ram_q;
            end
            r_addr <= w_last ? 3'd0 : r_addr + 3'd1;
          end
        end
        ST_IDLE: begin
          if (clear_req) begin
            r_state <= ST_CLEAR;
            r_addr  <= '0;
          end else if (w_go_req) begin
            r_state <= ST_CMP;
            r_user  <= userID;
            r_score <= currentGameScore;
          end
        end
        ST_CMP: begin
          if (w_hit) r_state <= ST_WRITE;
        end
        ST_WRITE: begin
          for (int unsigned i = 0; i < NUM_USERS; i++) begin
            if (r_user == 3'(i)) r_shadow[i] <= r_score;
          end
        end
        ST_CLEAR: begin
          for (int unsigned i = 0; i < NUM_USERS; i++) begin
            if (r_addr == 3'(i)) r_shadow[i] <= '0;
          end
          r_addr <= w_last ? 3'd0 : r_addr + 3'd1;
        end
        default: r_state <= ST_INIT;
      endcase
      // Pending work skips IDLE entirely so busy stays high; a request this cycle is newest.
      if (w_done) begin
        if (r_pend || w_go_req) begin
          r_state <= ST_CMP;
          r_pend  <= 1'b0;
          r_user  <= w_go_req ? userID : r_pend_user;
          r_score <= w_go_req ? currentGameScore : r_pend_score;
        end else begin
          r_state <= ST_IDLE;
        end
      end
    end
  end

  assign ram_wren       = (r_state == ST_WRITE) || (r_state == ST_CLEAR);
  assign ram_addr       = (r_state == ST_WRITE) ? r_user : r_addr;
  assign ram_data       = (r_state == ST_WRITE) ? r_score : '0;
  assign busy           = (r_state != ST_IDLE);
  assign new_high_score = (r_state == ST_WRITE);

  assign scoreUserAddr0 = r_shadow[0];
  assign scoreUserAddr1 = r_shadow[1];
  assign scoreUserAddr2 = r_shadow[2];
  assign scoreUserAddr3 = r_shadow[3];
  assign scoreUserAddr4 = r_shadow[4];
  assign scoreUserAddr5 = r_shadow[5];

endmodule

// File: tb/tb_high_score_ram_ctrl.sv
// Bench for high_score_ram_ctrl: behavioural 2-cycle RAM, vector table for game-end and clear
// requests, hand sequences for pending-during-INIT and reset in the middle of a write.
module tb_high_score_ram_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       access_granted = 1'b0;
  logic [2:0] userID = 3'd0;
  logic       game_over = 1'b0;
  logic [7:0] currentGameScore = 8'h00;
  logic       clear_req = 1'b0;
  logic [7:0] ram_q;
  logic [2:0] ram_addr;
  logic       ram_wren;
  logic [7:0] ram_data;
  logic [7:0] s0, s1, s2, s3, s4, s5;
  logic       busy;
  logic       new_high_score;

  high_score_ram_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .access_granted   (access_granted),
    .userID           (userID),
    .game_over        (game_over),
    .currentGameScore (currentGameScore),
    .clear_req        (clear_req),
    .ram_q            (ram_q),
    .ram_addr         (ram_addr),
    .ram_wren         (ram_wren),
    .ram_data         (ram_data),
    .scoreUserAddr0   (s0),
    .scoreUserAddr1   (s1),
    .scoreUserAddr2   (s2),
    .scoreUserAddr3   (s3),
    .scoreUserAddr4   (s4),
    .scoreUserAddr5   (s5),
    .busy             (busy),
    .new_high_score   (new_high_score)
  );

  always #5 clk = ~clk;

  // Registered address and registered output: two cycles from address to data.
  logic [7:0] mem [8];
  logic [2:0] ram_addr_q;
  always @(posedge clk) begin
    ram_addr_q <= ram_addr;
    ram_q      <= mem[ram_addr_q];
    if (ram_wren) mem[ram_addr] <= ram_data;
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [47:0] shadows();
    return {s0, s1, s2, s3, s4, s5};
  endfunction

  task automatic preload();
    mem[0] = 8'h12; mem[1] = 8'h34; mem[2] = 8'h05; mem[3] = 8'h99;
    mem[4] = 8'h00; mem[5] = 8'h47; mem[6] = 8'h00; mem[7] = 8'h00;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " busy"}, 64'(busy), 64'd1);
    check({tag, " wren"}, 64'(ram_wren), 64'd0);
    check({tag, " new"}, 64'(new_high_score), 64'd0);
    check({tag, " addr/data"}, 64'({ram_addr, ram_data}), 64'd0);
    check({tag, " shadows"}, 64'(shadows()), 64'd0);
  endtask

  // Watch results: busy-high samples, write and pulse counts, last write seen.
  int         m_busy, m_wr, m_new;
  logic [2:0] m_a;
  logic [7:0] m_d;

  // Sample each negedge until idle (bounded); drops one-cycle pulses after the first edge.
  // At iteration 'inject' a pending game_over (user 1, 0x60) is raised for one cycle.
  task automatic watch(input int start_busy, input int inject);
    m_busy = start_busy; m_wr = 0; m_new = 0; m_a = 3'd0; m_d = 8'h00;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      game_over = 1'b0;
      clear_req = 1'b0;
      if (ram_wren) begin
        m_wr++;
        m_a = ram_addr;
        m_d = ram_data;
      end
      if (new_high_score) m_new++;
      if (i == inject) begin
        game_over = 1'b1; access_granted = 1'b1; userID = 3'd1; currentGameScore = 8'h60;
      end
      if (!busy) break;
      m_busy++;
    end
  endtask

  typedef struct {
    logic        clr;
    logic        ag;
    logic [2:0]  user;
    logic [7:0]  score;
    int          busy_n;
    int          wr_n;
    int          new_n;
    logic [2:0]  a;
    logic [7:0]  d;
    logic [47:0] sh;
  } vec_t;

  vec_t vecs [8];

  initial begin
    vecs[0] = '{1'b0, 1'b1, 3'd2, 8'h20, 2, 1, 1, 3'd2, 8'h20, 48'h12_34_20_99_00_47};
    vecs[1] = '{1'b0, 1'b1, 3'd3, 8'h99, 1, 0, 0, 3'd0, 8'h00, 48'h12_34_20_99_00_47};
    vecs[2] = '{1'b0, 1'b1, 3'd3, 8'h50, 1, 0, 0, 3'd0, 8'h00, 48'h12_34_20_99_00_47};
    vecs[3] = '{1'b0, 1'b0, 3'd0, 8'hFF, 0, 0, 0, 3'd0, 8'h00, 48'h12_34_20_99_00_47};
    vecs[4] = '{1'b0, 1'b1, 3'd7, 8'hFF, 1, 0, 0, 3'd0, 8'h00, 48'h12_34_20_99_00_47};
    vecs[5] = '{1'b0, 1'b1, 3'd4, 8'h01, 2, 1, 1, 3'd4, 8'h01, 48'h12_34_20_99_01_47};
    vecs[6] = '{1'b1, 1'b1, 3'd0, 8'hFF, 6, 6, 0, 3'd5, 8'h00, 48'h00_00_00_00_00_00};
    vecs[7] = '{1'b0, 1'b1, 3'd5, 8'h01, 2, 1, 1, 3'd5, 8'h01, 48'h00_00_00_00_00_01};

    preload();
    #1;
    check_reset_vals("reset0");
    repeat (3) @(negedge clk);
    check_reset_vals("reset_held");

    // Initial load: busy for exactly 18 cycles, no writes.
    rst = 1'b1;
    watch(1, -1);
    check("init busy cycles", 64'(m_busy), 64'd18);
    check("init writes", 64'(m_wr), 64'd0);
    check("init shadows", 64'(shadows()), 64'h12_34_05_99_00_47);
    check("init addr", 64'(ram_addr), 64'd0);

    foreach (vecs[k]) begin
      clear_req        = vecs[k].clr;
      game_over        = 1'b1;
      access_granted   = vecs[k].ag;
      userID           = vecs[k].user;
      currentGameScore = vecs[k].score;
      watch(0, -1);
      check($sformatf("v%0d busy", k), 64'(m_busy), 64'(vecs[k].busy_n));
      check($sformatf("v%0d writes", k), 64'(m_wr), 64'(vecs[k].wr_n));
      check($sformatf("v%0d new", k), 64'(m_new), 64'(vecs[k].new_n));
      if (vecs[k].wr_n > 0)
        check($sformatf("v%0d last write", k), 64'({m_a, m_d}), 64'({vecs[k].a, vecs[k].d}));
      check($sformatf("v%0d shadows", k), 64'(shadows()), 64'(vecs[k].sh));
    end

    // Reset with a fresh table, then a game_over while INIT runs is serviced right after it.
    @(negedge clk);
    rst = 1'b0;
    preload();
    #1;
    check_reset_vals("reset1");
    @(negedge clk);
    rst = 1'b1;
    watch(1, 5);
    check("pend busy cycles", 64'(m_busy), 64'd20);
    check("pend writes", 64'(m_wr), 64'd1);
    check("pend new", 64'(m_new), 64'd1);
    check("pend write", 64'({m_a, m_d}), 64'({3'd1, 8'h60}));
    check("pend shadows", 64'(shadows()), 64'h12_60_05_99_00_47);

    // Second update interrupted by reset while in WRITE.
    game_over = 1'b1; access_granted = 1'b1; userID = 3'd0; currentGameScore = 8'h50;
    @(negedge clk);
    game_over = 1'b0;
    @(negedge clk);
    check("mid write wren", 64'({ram_wren, new_high_score, ram_addr, ram_data}),
          64'({1'b1, 1'b1, 3'd0, 8'h50}));
    #2 rst = 1'b0;
    #1;
    check_reset_vals("async reset");
    @(negedge clk);
    rst = 1'b1;
    watch(1, -1);
    check("reinit busy cycles", 64'(m_busy), 64'd18);
    check("reinit writes", 64'(m_wr), 64'd0);
    check("reinit shadows", 64'(shadows()), 64'h12_60_05_99_00_47);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
